// File: rtl/led_mode_pkg.sv
// Shared types and constants for the LED mode scheduler.
// Holds the FSM state enum, mode encodings, output widths and the
// walking one-hot helper used by the output decoder.
package led_mode_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned REQ_W   = 2;
    localparam int unsigned LED_W   = 5;
    localparam int unsigned PMOD_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SWITCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_GRAY  = 2'd0,
        MODE_BIN   = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_t;

    // One-hot LED position 1 << (c mod 5).
    function automatic logic [LED_W-1:0] walk_onehot(input logic [7:0] c);
        logic [7:0] r;
        r = c % 8'd5;
        return LED_W'(1) << r[2:0];
    endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchronizer plus optional debouncer.
// Macro BTN_DEBOUNCE_EN enables the debouncer (parameter DEB_LOG2).
// Ports: CLK, RST (async active-high), btn (raw), level (conditioned, registered).
module btn_cond
`ifdef BTN_DEBOUNCE_EN
#(
    parameter int unsigned DEB_LOG2 = 16
)
`endif
(
    input  logic CLK,
    input  logic RST,
    input  logic btn,
    output logic level
);

    logic sync1;
    logic sync2;

    // Two-stage synchronizer for the asynchronous button input.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

`ifdef BTN_DEBOUNCE_EN
    logic [DEB_LOG2-1:0] deb_cnt;
    logic                stable;

    // Accept a new level only after 2^DEB_LOG2 consecutive differing samples.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            deb_cnt <= '0;
            stable  <= 1'b0;
        end else if (sync2 == stable) begin
            deb_cnt <= '0;
        end else if (&deb_cnt) begin
            stable  <= sync2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_LOG2'(1);
        end
    end

    assign level = stable;
`else
    assign level = sync2;
`endif

endmodule

// File: rtl/led_mode_sched.sv
// LED mode scheduler: four button requesters, round-robin arbiter,
// IDLE/SWITCH/RUN FSM and a registered LED/PMOD pattern generator.
// Optional button debouncing via macro BTN_DEBOUNCE_EN.
// Ports: CLK, RST (async active-high), btn[3:0] requests,
//        leds[4:0], pmod[15:0] patterns, mode[1:0] granted mode, running.
module led_mode_sched
    import led_mode_pkg::*;
#(
    parameter int unsigned LOG2DELAY = 22,
    parameter int unsigned BITS      = 5,
    parameter int unsigned DEB_LOG2  = 16
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_REQ-1:0] btn,
    output logic [LED_W-1:0]  leds,
    output logic [PMOD_W-1:0] pmod,
    output logic [1:0]        mode,
    output logic              running
);

    // Reject unsupported configurations at elaboration.
    if (BITS < 5 || BITS > 8 || DEB_LOG2 == 0) begin : g_bad_cfg
        $error("led_mode_sched: BITS must be 5..8 and DEB_LOG2 nonzero");
    end

    logic [NUM_REQ-1:0]   level;
    logic [NUM_REQ-1:0]   level_q;
    logic [NUM_REQ-1:0]   edge_c;
    logic [NUM_REQ-1:0]   pending;
    logic [NUM_REQ-1:0]   grant_mask_c;
    logic [REQ_W-1:0]     last_grant;
    logic [REQ_W-1:0]     grant_idx_c;
    logic [REQ_W-1:0]     cand_c;
    logic                 grant_vld_c;
    logic [LOG2DELAY-1:0] presc;
    logic                 step_c;

    state_t               state, state_n;
    mode_t                mode_q, mode_n;
    logic [BITS-1:0]      cnt, cnt_n;
    logic [LED_W-1:0]     leds_c;
    logic [PMOD_W-1:0]    pmod_c;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_btn
        btn_cond
`ifdef BTN_DEBOUNCE_EN
        #(.DEB_LOG2(DEB_LOG2))
`endif
        u_btn_cond (
            .CLK   (CLK),
            .RST   (RST),
            .btn   (btn[i]),
            .level (level[i])
        );
    end

    assign edge_c = level & ~level_q;
    assign step_c = &presc;

    // Round-robin search starting at last_grant + 1.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = last_grant;
        cand_c      = last_grant;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand_c = REQ_W'(int'(last_grant) + k);
            if (!grant_vld_c && pending[cand_c]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand_c;
            end
        end
        grant_mask_c = grant_vld_c ? (NUM_REQ'(1) << grant_idx_c) : '0;
    end

    // Edge capture, pending bits, arbiter history and prescaler.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            level_q    <= '0;
            pending    <= '0;
            last_grant <= REQ_W'(NUM_REQ - 1);
            presc      <= '0;
        end else begin
            level_q <= level;
            // Edges on already-pending requesters simply merge into the set bit.
            pending <= (pending & ~grant_mask_c) | edge_c;
            if (grant_vld_c) begin
                last_grant <= grant_idx_c;
            end
            presc <= presc + LOG2DELAY'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            mode_q  <= MODE_GRAY;
            cnt     <= '0;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            mode_q  <= mode_n;
            cnt     <= cnt_n;
            running <= (state_n == RUN);
        end
    end

    // Next-state logic; a grant always takes priority over a step.
    always_comb begin
        state_n = state;
        mode_n  = mode_q;
        cnt_n   = cnt;
        case (state)
            IDLE: begin
                if (grant_vld_c) begin
                    mode_n  = mode_t'(grant_idx_c);
                    cnt_n   = '0;
                    state_n = SWITCH;
                end
            end
            SWITCH: begin
                if (grant_vld_c) begin
                    mode_n = mode_t'(grant_idx_c);
                    cnt_n  = '0;
                end else if (step_c) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                if (grant_vld_c) begin
                    cnt_n = '0;
                    if (mode_t'(grant_idx_c) != mode_q) begin
                        mode_n  = mode_t'(grant_idx_c);
                        state_n = SWITCH;
                    end
                end else if (step_c) begin
                    cnt_n = cnt + BITS'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Pattern decode from current state/mode/count.
    always_comb begin
        leds_c = '0;
        pmod_c = '0;
        if (state == RUN) begin
            case (mode_q)
                MODE_GRAY: begin
                    leds_c = LED_W'(cnt ^ (cnt >> 1));
                    pmod_c = PMOD_W'(1) << cnt[3:0];
                end
                MODE_BIN: begin
                    leds_c = LED_W'(cnt);
                    pmod_c = PMOD_W'(1) << cnt[3:0];
                end
                MODE_WALK: begin
                    leds_c = walk_onehot(8'(cnt));
                    pmod_c = PMOD_W'(1) << cnt[3:0];
                end
                default: begin
                    leds_c = {LED_W{cnt[0]}};
                    pmod_c = {PMOD_W{cnt[0]}};
                end
            endcase
        end
    end

    // Output pattern registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            leds <= '0;
            pmod <= '0;
        end else begin
            leds <= leds_c;
            pmod <= pmod_c;
        end
    end

    assign mode = mode_q;

endmodule

// File: doc/led_mode_sched.md
LED_MODE_SCHED -- requirements
Module: led_mode_sched

Interface
REQ-001 The block SHALL have parameter LOG2DELAY, default 22, meaning log2 of CLK cycles per display step.
REQ-002 The block SHALL have parameter BITS, default 5, meaning the step counter width (5..8).
REQ-003 The block SHALL have parameter DEB_LOG2, default 16, meaning log2 of CLK cycles a button level must be stable to be accepted.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state on rising edge.
REQ-005 The block SHALL have port RST, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port btn, input, 4 bits: raw asynchronous requester buttons, active-high; bit i requests mode i.
REQ-007 The block SHALL have port leds, output, 5 bits: registered LED pattern.
REQ-008 The block SHALL have port pmod, output, 16 bits: registered PMOD pattern.
REQ-009 The block SHALL have port mode, output, 2 bits: currently granted mode.
REQ-010 The block SHALL have port running, output, 1 bit: high in state RUN.

Function
REQ-011 Each btn bit SHALL pass a 2-flop synchronizer; a rising edge of the conditioned level SHALL set that requester's pending bit.
REQ-012 Prescaler SHALL count 0..2^LOG2DELAY-1, wrap to 0, and assert internal step for exactly one cycle at wrap.
REQ-013 Arbiter SHALL grant at most one pending requester per cycle, round-robin, starting search at (last_grant+1) mod 4; grant SHALL clear only the granted pending bit.
REQ-014 An edge arriving on a requester whose pending bit is already set SHALL be absorbed (no counting).
REQ-015 The FSM SHALL have states IDLE, SWITCH, and RUN.
REQ-016 IDLE: leds=0, pmod=0; any grant SHALL load mode, clear step counter, and go to SWITCH.
REQ-017 SWITCH: outputs SHALL be 0; on next step pulse go to RUN; a new grant in SWITCH SHALL reload mode and stay in SWITCH.
REQ-018 RUN: step counter (BITS wide) SHALL increment on step and wrap 2^BITS-1 -> 0.
REQ-019 A grant in RUN for a different mode SHALL clear the step counter and go to SWITCH; a grant for the same mode SHALL clear the step counter and stay in RUN.
REQ-020 Step and grant in the same cycle: the grant SHALL win (counter cleared, not incremented).
REQ-021 Mode 0 SHALL drive leds to the 5 LSBs of Gray(cnt), computed as cnt XOR (cnt>>1); mode 1 SHALL drive leds to the 5 LSBs of cnt.
REQ-022 Mode 2 SHALL drive leds to the one-hot 1<<(cnt mod 5); mode 3 SHALL drive leds to all-ones when cnt[0]=1 and zero otherwise.
REQ-023 pmod SHALL equal 1<<(cnt mod 16) in modes 0-2, with bit 15 mapped to pmod[15], and SHALL equal all-ones/zero with leds in mode 3.
REQ-024 leds and pmod SHALL update one cycle after the counter/state change (registered).

Reset
REQ-025 RST asserted SHALL force IDLE, and clear the step counter, prescaler, pending bits, synchronizers, debouncers, and outputs.
REQ-026 Under RST, last_grant SHALL be 3, so requester 0 is searched first; mode SHALL be 0 and running SHALL be 0.
REQ-027 Reset asserted mid-RUN SHALL discard all pending requests; after release the block SHALL stay in IDLE until a new edge.

Configuration
REQ-028 With BTN_DEBOUNCE_EN defined, a synchronized level SHALL be accepted only after 2^DEB_LOG2 consecutive equal samples.
REQ-029 Without BTN_DEBOUNCE_EN, the synchronizer output SHALL be used directly, and DEB_LOG2 SHALL be ignored.

Structure
REQ-030 Package led_mode_pkg SHALL hold the state enum (IDLE/SWITCH/RUN), the mode encodings MODE_GRAY=0, MODE_BIN=1, MODE_WALK=2, MODE_BLINK=3, and NUM_REQ=4.
REQ-031 The per-button synchronizer plus optional debouncer SHALL be sub-module btn_cond, instantiated 4 times.

Verification (LOG2DELAY=2, DEB_LOG2=2, BITS=5)
REQ-032 Reset, then pulse btn[1] -> SWITCH, then RUN after the next step; leds sequence 0,1,2,3 on successive steps.
REQ-033 Rising edges on btn[0] and btn[2] in the same cycle with last_grant=3 -> mode 0 granted first, then mode 2 on the next cycle; final mode=2.
REQ-034 In RUN mode 0 at cnt=31, apply a step -> cnt=0, leds=00000, pmod=0x0001.
REQ-035 Grant of the same mode coincident with step at cnt=7 -> cnt=0, state remains RUN.
REQ-036 Assert RST mid-RUN with btn[3] pending -> outputs 0, IDLE, and no grant after release.
REQ-037 With BTN_DEBOUNCE_EN, a 2-cycle glitch on btn[2] -> no grant; a stable level of 8+ cycles -> exactly one grant.
